// File: rtl/control_v2.sv
// Second-generation control unit for the accumulator processor.
// Falling-edge state machine with memory handshake, operand wait, HALT/resume and sticky illegal-opcode flag.
module control_v2 #(
    parameter int OPC_W           = 8,
    parameter int MEM_WAIT        = 1,
    parameter int HALT_ON_ILLEGAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OPC_W-1:0] opcode,
    input  logic             nflg,
    input  logic             zflg,
    input  logic             cflg,
    input  logic             mem_ready,
    input  logic             run,
    output logic             load_ac,
    output logic             load_iru,
    output logic             load_irl,
    output logic             load_pc,
    output logic             inc_pc,
    output logic             fetch,
    output logic             store_mem,
    output logic             halted,
    output logic             illegal,
    output logic [4:0]       State
);

    typedef enum logic [4:0] {
        START     = 5'd0,
        PREPU     = 5'd1,
        FETCHU    = 5'd2,
        FETCHL    = 5'd3,
        EXECNOP   = 5'd4,
        EXECCLR   = 5'd5,
        EXECCL2   = 5'd6,
        EXECWAIT  = 5'd7,
        EXECCL31  = 5'd8,
        EXECSTORE = 5'd9,
        JUMP      = 5'd10,
        JNEG      = 5'd11,
        JPOSZ     = 5'd12,
        JZERO     = 5'd13,
        JNZER     = 5'd14,
        JCARRY    = 5'd15,
        JNCARRY   = 5'd16,
        HALT      = 5'd17,
        ILLEGAL   = 5'd18
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);

    state_t     state;
    state_t     next_state;
    logic [3:0] wait_cnt;
    logic       illegal_q;
    logic       upper_zero;
    logic [7:0] opc_lo;

    assign opc_lo = opcode[7:0];

    // Opcodes wider than a byte are only valid when the extra bits are clear.
    generate
        if (OPC_W > 8) begin : g_upper
            assign upper_zero = ~|opcode[OPC_W-1:8];
        end else begin : g_no_upper
            assign upper_zero = 1'b1;
        end
    endgenerate

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state     <= START;
            wait_cnt  <= 4'd0;
            illegal_q <= 1'b0;
        end else begin
            state <= next_state;
            if (state == EXECWAIT) begin
                wait_cnt <= wait_cnt + 4'd1;
            end else begin
                wait_cnt <= 4'd0;
            end
            if (state == ILLEGAL) begin
                illegal_q <= 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        load_ac    = 1'b0;
        load_iru   = 1'b0;
        load_irl   = 1'b0;
        load_pc    = 1'b0;
        inc_pc     = 1'b0;
        fetch      = 1'b0;
        store_mem  = 1'b0;
        halted     = 1'b0;
        case (state)
            START: next_state = PREPU;
            PREPU: begin
                fetch      = 1'b1;
                next_state = FETCHU;
            end
            FETCHU: begin
                fetch = 1'b1;
                if (mem_ready) begin
                    load_iru = 1'b1;
                    inc_pc   = 1'b1;
                    if (opcode == OPC_W'(8'h00)) begin
                        next_state = EXECNOP;
                    end else if (opcode == OPC_W'(8'h04)) begin
                        next_state = EXECCLR;
                    end else if (opcode == OPC_W'(8'h1F)) begin
                        next_state = HALT;
                    end else begin
                        next_state = FETCHL;
                    end
                end
            end
            FETCHL: begin
                fetch = 1'b1;
                if (mem_ready) begin
                    load_irl = 1'b1;
                    inc_pc   = 1'b1;
                    case (opc_lo)
                        8'h02, 8'h06, 8'h08, 8'h0E, 8'h0F:
                            next_state = EXECCL2;
                        8'h01, 8'h05, 8'h07, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D:
                            next_state = EXECWAIT;
                        8'h03:   next_state = EXECSTORE;
                        8'h10:   next_state = JUMP;
                        8'h11:   next_state = JNEG;
                        8'h12:   next_state = JPOSZ;
                        8'h13:   next_state = JZERO;
                        8'h14:   next_state = JNZER;
                        8'h15:   next_state = JCARRY;
                        8'h16:   next_state = JNCARRY;
                        default: next_state = ILLEGAL;
                    endcase
                    if (!upper_zero) begin
                        next_state = ILLEGAL;
                    end
                end
            end
            EXECNOP: next_state = PREPU;
            EXECCLR, EXECCL2: begin
                load_ac    = 1'b1;
                next_state = PREPU;
            end
            EXECWAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    next_state = EXECCL31;
                end
            end
            EXECCL31: begin
                if (mem_ready) begin
                    load_ac    = 1'b1;
                    next_state = PREPU;
                end
            end
            EXECSTORE: begin
                store_mem = 1'b1;
                if (mem_ready) begin
                    next_state = PREPU;
                end
            end
            JUMP: begin
                load_pc    = 1'b1;
                next_state = PREPU;
            end
            JNEG: begin
                load_pc    = nflg;
                next_state = PREPU;
            end
            JPOSZ: begin
                load_pc    = zflg | ~nflg;
                next_state = PREPU;
            end
            JZERO: begin
                load_pc    = zflg;
                next_state = PREPU;
            end
            JNZER: begin
                load_pc    = ~zflg;
                next_state = PREPU;
            end
            JCARRY: begin
                load_pc    = cflg;
                next_state = PREPU;
            end
            JNCARRY: begin
                load_pc    = ~cflg;
                next_state = PREPU;
            end
            HALT: begin
                halted = 1'b1;
                if (run) begin
                    next_state = PREPU;
                end
            end
            ILLEGAL: begin
                next_state = (HALT_ON_ILLEGAL != 0) ? HALT : PREPU;
            end
            default: next_state = START;
        endcase
    end

    assign illegal = illegal_q;
    assign State   = state;

endmodule

// File: tb/tb_control_v2.sv
// Directed bench for control_v2: expected state/strobe vectors are queued per step
// and compared mid-cycle, away from the falling clock edge that updates the FSM.
module tb_control_v2;

    localparam int OPC_W = 10;

    localparam logic [8:0] M_AC  = 9'h100;
    localparam logic [8:0] M_IU  = 9'h080;
    localparam logic [8:0] M_IL  = 9'h040;
    localparam logic [8:0] M_PC  = 9'h020;
    localparam logic [8:0] M_INC = 9'h010;
    localparam logic [8:0] M_F   = 9'h008;
    localparam logic [8:0] M_ST  = 9'h004;
    localparam logic [8:0] M_H   = 9'h002;
    localparam logic [8:0] M_ILL = 9'h001;
    localparam logic [8:0] M_FU  = M_F | M_IU | M_INC;
    localparam logic [8:0] M_FL  = M_F | M_IL | M_INC;

    localparam logic [4:0] S_START = 5'd0,  S_PREPU = 5'd1,  S_FETCHU = 5'd2,  S_FETCHL = 5'd3;
    localparam logic [4:0] S_NOP   = 5'd4,  S_CLR   = 5'd5,  S_WAIT   = 5'd7,  S_CL31   = 5'd8;
    localparam logic [4:0] S_STORE = 5'd9,  S_JPOSZ = 5'd12, S_JZERO  = 5'd13, S_JCARRY = 5'd15;
    localparam logic [4:0] S_JNC   = 5'd16, S_HALT  = 5'd17, S_ILL    = 5'd18;

    typedef struct {
        logic [4:0] st;
        logic [8:0] outs;
        string      tag;
    } exp_t;

    logic             clk;
    logic             reset;
    logic [OPC_W-1:0] opcode;
    logic             nflg, zflg, cflg, mem_ready, run;
    logic             load_ac, load_iru, load_irl, load_pc, inc_pc, fetch, store_mem, halted, illegal;
    logic [4:0]       State;

    exp_t exp_q[$];
    int   tests;
    int   fails;

    control_v2 #(.OPC_W(OPC_W), .MEM_WAIT(3), .HALT_ON_ILLEGAL(0)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .nflg(nflg), .zflg(zflg), .cflg(cflg),
        .mem_ready(mem_ready), .run(run), .load_ac(load_ac), .load_iru(load_iru),
        .load_irl(load_irl), .load_pc(load_pc), .inc_pc(inc_pc), .fetch(fetch),
        .store_mem(store_mem), .halted(halted), .illegal(illegal), .State(State)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic check_output();
        exp_t       e;
        logic [8:0] obs;
        obs = {load_ac, load_iru, load_irl, load_pc, inc_pc, fetch, store_mem, halted, illegal};
        tests++;
        assert (exp_q.size() > 0) else begin
            fails++;
            $error("[TB] FAIL scoreboard empty at time %0t", $time);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            assert (State === e.st) else begin
                fails++;
                $error("[TB] FAIL %s state: observed %0d expected %0d", e.tag, State, e.st);
            end
            tests++;
            assert (obs === e.outs) else begin
                fails++;
                $error("[TB] FAIL %s outputs: observed %b expected %b", e.tag, obs, e.outs);
            end
        end
    endtask

    // One FSM cycle: drive inputs after the falling edge, check mid-cycle, return after next falling edge.
    task automatic apply_stimulus(input logic mr, input logic rn, input logic [4:0] st,
                                  input logic [8:0] outs, input string tag);
        exp_t e;
        mem_ready = mr;
        run       = rn;
        e.st      = st;
        e.outs    = outs;
        e.tag     = tag;
        exp_q.push_back(e);
        @(posedge clk);
        check_output();
        @(negedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        tests     = 0;
        fails     = 0;
        reset     = 1'b0;
        opcode    = '0;
        nflg      = 1'b0;
        zflg      = 1'b0;
        cflg      = 1'b0;
        mem_ready = 1'b1;
        run       = 1'b0;
        @(negedge clk);
        #1;
        apply_stimulus(1, 0, S_START, 9'h000, "in_reset");
        reset = 1'b1;

        // NOP: 0,1,2,4,1
        opcode = 10'h000;
        apply_stimulus(1, 0, S_START,  9'h000, "nop_start");
        apply_stimulus(1, 0, S_PREPU,  M_F,    "nop_prepu");
        apply_stimulus(1, 0, S_FETCHU, M_FU,   "nop_fetchu");
        apply_stimulus(1, 0, S_NOP,    9'h000, "nop_exec");
        apply_stimulus(1, 0, S_PREPU,  M_F,    "nop_prepu2");

        // Operand read with three wait cycles and memory stalls
        opcode = 10'h001;
        apply_stimulus(0, 0, S_FETCHU, M_F,    "ld_fetchu_stall");
        apply_stimulus(1, 0, S_FETCHU, M_FU,   "ld_fetchu");
        apply_stimulus(0, 0, S_FETCHL, M_F,    "ld_fetchl_stall");
        apply_stimulus(1, 0, S_FETCHL, M_FL,   "ld_fetchl");
        apply_stimulus(1, 0, S_WAIT,   9'h000, "ld_wait1");
        apply_stimulus(1, 0, S_WAIT,   9'h000, "ld_wait2");
        apply_stimulus(1, 0, S_WAIT,   9'h000, "ld_wait3");
        apply_stimulus(0, 0, S_CL31,   9'h000, "ld_cl31_stall");
        apply_stimulus(1, 0, S_CL31,   M_AC,   "ld_cl31");
        apply_stimulus(1, 0, S_PREPU,  M_F,    "ld_prepu");

        // Store held by memory for two cycles
        opcode = 10'h003;
        apply_stimulus(1, 0, S_FETCHU, M_FU,   "st_fetchu");
        apply_stimulus(1, 0, S_FETCHL, M_FL,   "st_fetchl");
        apply_stimulus(0, 0, S_STORE,  M_ST,   "st_exec1");
        apply_stimulus(0, 0, S_STORE,  M_ST,   "st_exec2");
        apply_stimulus(1, 0, S_STORE,  M_ST,   "st_exec3");
        apply_stimulus(1, 0, S_PREPU,  M_F,    "st_prepu");

        // One-byte clear
        opcode = 10'h004;
        apply_stimulus(1, 0, S_FETCHU, M_FU,   "clr_fetchu");
        apply_stimulus(1, 0, S_CLR,    M_AC,   "clr_exec");
        apply_stimulus(1, 0, S_PREPU,  M_F,    "clr_prepu");

        // Conditional jumps
        opcode = 10'h015;
        cflg   = 1'b1;
        apply_stimulus(1, 0, S_FETCHU, M_FU,   "jc_fetchu");
        apply_stimulus(1, 0, S_FETCHL, M_FL,   "jc_fetchl");
        apply_stimulus(1, 0, S_JCARRY, M_PC,   "jc_taken");
        apply_stimulus(1, 0, S_PREPU,  M_F,    "jc_prepu");
        opcode = 10'h016;
        apply_stimulus(1, 0, S_FETCHU, M_FU,   "jnc_fetchu");
        apply_stimulus(1, 0, S_FETCHL, M_FL,   "jnc_fetchl");
        apply_stimulus(1, 0, S_JNC,    9'h000, "jnc_not_taken");
        apply_stimulus(1, 0, S_PREPU,  M_F,    "jnc_prepu");
        opcode = 10'h012;
        cflg   = 1'b0;
        nflg   = 1'b1;
        apply_stimulus(1, 0, S_FETCHU, M_FU,   "jposz_fetchu");
        apply_stimulus(1, 0, S_FETCHL, M_FL,   "jposz_fetchl");
        apply_stimulus(1, 0, S_JPOSZ,  9'h000, "jposz_not_taken");
        apply_stimulus(1, 0, S_PREPU,  M_F,    "jposz_prepu");
        opcode = 10'h013;
        zflg   = 1'b1;
        apply_stimulus(1, 0, S_FETCHU, M_FU,   "jz_fetchu");
        apply_stimulus(1, 0, S_FETCHL, M_FL,   "jz_fetchl");
        apply_stimulus(1, 0, S_JZERO,  M_PC,   "jz_taken");
        apply_stimulus(1, 0, S_PREPU,  M_F,    "jz_prepu");
        nflg = 1'b0;
        zflg = 1'b0;

        // HALT held for five cycles, resume raised in the fifth
        opcode = 10'h01F;
        apply_stimulus(1, 0, S_FETCHU, M_FU,   "halt_fetchu");
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1, 0, S_HALT, M_H,  "halt_hold");
        end
        apply_stimulus(1, 1, S_HALT,   M_H,    "halt_resume");
        apply_stimulus(1, 0, S_PREPU,  M_F,    "halt_prepu");

        // run already high on entry still yields one HALT cycle
        apply_stimulus(1, 1, S_FETCHU, M_FU,   "halt2_fetchu");
        apply_stimulus(1, 1, S_HALT,   M_H,    "halt2_min");
        apply_stimulus(1, 0, S_PREPU,  M_F,    "halt2_prepu");

        // Illegal opcode: skip and resume, flag becomes sticky
        opcode = 10'h01A;
        apply_stimulus(1, 0, S_FETCHU, M_FU,          "ill_fetchu");
        apply_stimulus(1, 0, S_FETCHL, M_FL,          "ill_fetchl");
        apply_stimulus(1, 0, S_ILL,    9'h000,        "ill_state");
        apply_stimulus(1, 0, S_PREPU,  M_F | M_ILL,   "ill_prepu");
        opcode = 10'h000;
        apply_stimulus(1, 0, S_FETCHU, M_FU | M_ILL,  "ill_sticky_fetchu");
        apply_stimulus(1, 0, S_NOP,    M_ILL,         "ill_sticky_nop");
        apply_stimulus(1, 0, S_PREPU,  M_F | M_ILL,   "ill_sticky_prepu");

        // Nonzero bit above the low byte makes a known opcode illegal
        opcode = 10'h110;
        apply_stimulus(1, 0, S_FETCHU, M_FU | M_ILL,  "wide_fetchu");
        apply_stimulus(1, 0, S_FETCHL, M_FL | M_ILL,  "wide_fetchl");
        apply_stimulus(1, 0, S_ILL,    M_ILL,         "wide_illegal");
        apply_stimulus(1, 0, S_PREPU,  M_F | M_ILL,   "wide_prepu");

        // Asynchronous reset in the middle of a FETCHL cycle
        opcode = 10'h001;
        apply_stimulus(1, 0, S_FETCHU, M_FU | M_ILL,  "rst_fetchu");
        mem_ready = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        e.st   = S_START;
        e.outs = 9'h000;
        e.tag  = "async_reset";
        exp_q.push_back(e);
        check_output();
        @(negedge clk);
        #1;
        apply_stimulus(1, 0, S_START, 9'h000, "reset_hold");
        reset = 1'b1;
        apply_stimulus(1, 0, S_START, 9'h000, "post_reset_start");
        apply_stimulus(1, 0, S_PREPU, M_F,    "post_reset_prepu");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
